fios_res_collector: RTL and testbench

FIOS_RES_COLLECTOR -- requirements
Module: fios_res_collector

---
 rtl/fios_res_collector.sv | 156 +++++++++++++++
 tb/tb_fios_res_collector.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fios_res_collector.sv
// Collects the FIOS result digits from the last PE, propagates carries, and drains them downstream.
// Define FIOS_RES_FINAL_SUB_EN to add the conditional final subtraction of the modulus.
module fios_res_collector #(
   parameter int S     = 8,
   parameter int CNT_W = $clog2(S+1)
) (
   input  logic        clock_i,
   input  logic        reset_i,
   input  logic        digit_valid_i,
   input  logic [16:0] RES_i,
   input  logic [16:0] carry_i,
   input  logic [16:0] p_i,
   input  logic        last_i,
   input  logic        res_ready_i,
   output logic        res_valid_o,
   output logic [16:0] res_o,
   output logic        res_last_o,
   output logic        top_o,
   output logic        busy_o,
   output logic        err_o
);
   localparam int AW = (S > 1) ? $clog2(S) : 1;

   typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cidx_q, cidx_d, didx_q, didx_d;
   logic [17:0]      acc_q, acc_d;
   logic             err_q, err_d;
   logic [16:0]      buf_r_q [S];
   logic [34:0]      v;
   logic [17:0]      acc_next;
   logic             accept, idx_last, drain_last, top_fin;

   assign v          = 35'(RES_i) + 35'(acc_q);
   assign acc_next   = v[34:17] + 18'(carry_i);
   assign top_fin    = (acc_next != 18'd0);
   assign accept     = digit_valid_i && (state_q != DRAIN);
   assign idx_last   = (cidx_q == CNT_W'(S-1));
   assign drain_last = (didx_q == CNT_W'(S-1));

`ifdef FIOS_RES_FINAL_SUB_EN
   logic        bw_q, bw_d, sel_q, sel_d;
   logic [16:0] buf_d_q [S];
   logic [17:0] diff;

   assign diff = {1'b0, v[16:0]} - {1'b0, p_i} - {17'b0, bw_q};
`else
   logic top_q, top_d;
   logic unused_p;

   assign unused_p = ^p_i;
`endif

   always_comb begin
      state_d = state_q;
      cidx_d  = cidx_q;
      didx_d  = didx_q;
      acc_d   = acc_q;
      err_d   = err_q;
`ifdef FIOS_RES_FINAL_SUB_EN
      bw_d    = bw_q;
      sel_d   = sel_q;
`else
      top_d   = top_q;
`endif
      unique case (state_q)
         IDLE, COLLECT: begin
            if (digit_valid_i) begin
               state_d = COLLECT;
               acc_d   = acc_next;
               cidx_d  = cidx_q + CNT_W'(1);
`ifdef FIOS_RES_FINAL_SUB_EN
               bw_d    = diff[17];
`endif
               // A misplaced or missing last_i still closes the result so the drain stays in lockstep.
               if (last_i || idx_last) begin
                  state_d = DRAIN;
                  acc_d   = '0;
                  cidx_d  = '0;
                  if (last_i != idx_last) err_d = 1'b1;
                  if (|acc_next[17:1])    err_d = 1'b1;
`ifdef FIOS_RES_FINAL_SUB_EN
                  bw_d    = 1'b0;
                  sel_d   = top_fin | ~diff[17];
`else
                  top_d   = top_fin;
`endif
               end
            end
         end
         DRAIN: begin
            if (digit_valid_i) err_d = 1'b1;
            if (res_ready_i) begin
               didx_d = didx_q + CNT_W'(1);
               if (drain_last) begin
                  didx_d  = '0;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         cidx_q  <= '0;
         didx_q  <= '0;
         acc_q   <= '0;
         err_q   <= 1'b0;
`ifdef FIOS_RES_FINAL_SUB_EN
         bw_q    <= 1'b0;
         sel_q   <= 1'b0;
`else
         top_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cidx_q  <= cidx_d;
         didx_q  <= didx_d;
         acc_q   <= acc_d;
         err_q   <= err_d;
`ifdef FIOS_RES_FINAL_SUB_EN
         bw_q    <= bw_d;
         sel_q   <= sel_d;
`else
         top_q   <= top_d;
`endif
      end
   end

   // Digit storage needs no reset: contents are only read after a full collect.
   always_ff @(posedge clock_i) begin
      if (accept) begin
         buf_r_q[cidx_q[AW-1:0]] <= v[16:0];
`ifdef FIOS_RES_FINAL_SUB_EN
         buf_d_q[cidx_q[AW-1:0]] <= diff[16:0];
`endif
      end
   end

   assign res_valid_o = (state_q == DRAIN);
   assign res_last_o  = res_valid_o && drain_last;
   assign busy_o      = (state_q != IDLE);
   assign err_o       = err_q;
`ifdef FIOS_RES_FINAL_SUB_EN
   assign res_o = sel_q ? buf_d_q[didx_q[AW-1:0]] : buf_r_q[didx_q[AW-1:0]];
   assign top_o = 1'b0;
`else
   assign res_o = buf_r_q[didx_q[AW-1:0]];
   assign top_o = res_last_o & top_q;
`endif

endmodule

// File: tb/tb_fios_res_collector.sv
// Bench for fios_res_collector (S=4): expected digits come from the whole-number value of each result.
// Builds with or without FIOS_RES_FINAL_SUB_EN.
module tb_fios_res_collector;
   localparam int S  = 4;
   localparam int DW = S*17;

   logic        clock_i = 1'b0;
   logic        reset_i = 1'b1;
   logic        digit_valid_i = 1'b0;
   logic [16:0] RES_i = '0, carry_i = '0, p_i = '0;
   logic        last_i = 1'b0;
   logic        res_ready_i = 1'b1;
   logic        res_valid_o, res_last_o, top_o, busy_o, err_o;
   logic [16:0] res_o;

   fios_res_collector #(.S(S)) dut (
      .clock_i(clock_i), .reset_i(reset_i), .digit_valid_i(digit_valid_i),
      .RES_i(RES_i), .carry_i(carry_i), .p_i(p_i), .last_i(last_i),
      .res_ready_i(res_ready_i), .res_valid_o(res_valid_o), .res_o(res_o),
      .res_last_o(res_last_o), .top_o(top_o), .busy_o(busy_o), .err_o(err_o)
   );

   always #5 clock_i = ~clock_i;

   typedef struct {
      logic [16:0] d;
      logic        last;
      logic        top;
      logic        care;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;
   logic rdy_tog = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Result = sum of RES digits plus carries one digit up; top is anything above S digits.
   task automatic push_model(input logic [DW-1:0] r, input logic [DW-1:0] c, input logic [DW-1:0] p);
      logic [127:0] t, pv, low, mask, out;
      logic         top, top_exp;
      exp_t         e;
      t = '0; pv = '0;
      for (int k = 0; k < S; k++) begin
         t  = t  + (128'(r[17*k +: 17]) << (17*k));
         t  = t  + (128'(c[17*k +: 17]) << (17*(k+1)));
         pv = pv + (128'(p[17*k +: 17]) << (17*k));
      end
      mask = (128'(1) << DW) - 128'(1);
      low  = t & mask;
      top  = ((t >> DW) != 128'd0);
`ifdef FIOS_RES_FINAL_SUB_EN
      out     = (top || low >= pv) ? ((low - pv) & mask) : low;
      top_exp = 1'b0;
`else
      out     = low;
      top_exp = top;
`endif
      for (int k = 0; k < S; k++) begin
         e.d = out[17*k +: 17]; e.last = (k == S-1); e.top = top_exp; e.care = 1'b1;
         exp_q.push_back(e);
      end
   endtask

   task automatic push_lit(input logic [DW-1:0] d);
      exp_t e;
      for (int k = 0; k < S; k++) begin
         e.d = d[17*k +: 17]; e.last = (k == S-1); e.top = 1'b0; e.care = 1'b1;
         exp_q.push_back(e);
      end
   endtask

   task automatic push_dc();
      exp_t e;
      for (int k = 0; k < S; k++) begin
         e.d = '0; e.last = (k == S-1); e.top = 1'b0; e.care = 1'b0;
         exp_q.push_back(e);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 right after the last digit is accepted.
   task automatic send(input logic [DW-1:0] r, input logic [DW-1:0] c, input logic [DW-1:0] p,
                       input int last_at);
      for (int k = 0; k <= last_at; k++) begin
         digit_valid_i = 1'b1;
         RES_i   = r[17*k +: 17];
         carry_i = c[17*k +: 17];
         p_i     = p[17*k +: 17];
         last_i  = (k == last_at);
         if (k == last_at) chk("valid_before_last", 32'(res_valid_o), 32'd0);
         @(posedge clock_i); #1;
      end
      digit_valid_i = 1'b0;
      last_i = 1'b0;
      chk("valid_latency", 32'(res_valid_o), 32'd1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy_o && n < 200) begin
         @(posedge clock_i); #1;
         n++;
      end
      chk("drain_timeout", 32'(busy_o), 32'd0);
      chk("digits_left", 32'(exp_q.size()), 32'd0);
   endtask

   always @(posedge clock_i) begin
      #1;
      res_ready_i = rdy_tog ? ~res_ready_i : 1'b1;
   end

   logic        prev_stall = 1'b0;
   logic [16:0] prev_res = '0;

   always @(negedge clock_i) begin
      exp_t e;
      if (reset_i) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && res_valid_o) chk("stall_stable", 32'(res_o), 32'(prev_res));
         if (!res_valid_o) chk("last_without_valid", 32'(res_last_o), 32'd0);
         if (res_valid_o && res_ready_i) begin
            if (exp_q.size() == 0) begin
               chk("extra_digit", 32'(res_valid_o), 32'd0);
            end else begin
               e = exp_q.pop_front();
               if (e.care) chk("res_digit", 32'(res_o), 32'(e.d));
               chk("res_last", 32'(res_last_o), 32'(e.last));
               if (e.care && e.last) chk("top", 32'(top_o), 32'(e.top));
            end
         end
         prev_stall = res_valid_o && !res_ready_i;
         prev_res   = res_o;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] ra, ca, pa, z;
      z = '0;
      repeat (3) @(posedge clock_i);
      #1;
      chk("rst_valid", 32'(res_valid_o), 32'd0);
      chk("rst_last",  32'(res_last_o),  32'd0);
      chk("rst_top",   32'(top_o),       32'd0);
      chk("rst_busy",  32'(busy_o),      32'd0);
      chk("rst_err",   32'(err_o),       32'd0);
      reset_i = 1'b0;
      @(posedge clock_i); #1;

      push_lit({17'd4, 17'd3, 17'd2, 17'd1});
      send({17'd4, 17'd3, 17'd2, 17'd1}, z, z, S-1);
      chk("busy_in_drain", 32'(busy_o), 32'd1);
      wait_idle();

      // Back-to-back: first digit presented in the cycle right after returning to IDLE.
      push_lit({17'd0, 17'd0, 17'd1, 17'h1FFFF});
      send({17'd0, 17'd0, 17'd0, 17'h1FFFF}, {17'd0, 17'd0, 17'd0, 17'd1}, z, S-1);
      wait_idle();
      chk("err_clean", 32'(err_o), 32'd0);

      ra = {17'h00010, 17'h1FFFF, 17'h0ABCD, 17'h1F00F};
      ca = {17'h00000, 17'h00003, 17'h1FFFF, 17'h00002};
      pa = {17'h00010, 17'h1FFFF, 17'h0ABCD, 17'h1F010};
      push_model(ra, ca, pa);
      send(ra, ca, pa, S-1);
      wait_idle();

      ra = {17'h00005, 17'h0, 17'h0, 17'h0};
      ca = {17'h00001, 17'h0, 17'h0, 17'h0};
      push_model(ra, ca, z);
      send(ra, ca, z, S-1);
      wait_idle();
      chk("err_top_ok", 32'(err_o), 32'd0);

`ifdef FIOS_RES_FINAL_SUB_EN
      push_lit({17'd0, 17'd0, 17'd0, 17'd2});
      send({17'd0, 17'd0, 17'd0, 17'd7}, z, {17'd0, 17'd0, 17'd0, 17'd5}, S-1);
      wait_idle();
      push_lit({17'd0, 17'd0, 17'd0, 17'd3});
      send({17'd0, 17'd0, 17'd0, 17'd3}, z, {17'd0, 17'd0, 17'd0, 17'd5}, S-1);
      wait_idle();
`endif

      rdy_tog = 1'b1;
      ra = {17'h13579, 17'h02468, 17'h1ACE0, 17'h0BDF1};
      ca = {17'h00000, 17'h00010, 17'h00000, 17'h00005};
      push_model(ra, ca, ra);
      send(ra, ca, ra, S-1);
      wait_idle();
      rdy_tog = 1'b0;
      chk("err_after_stall", 32'(err_o), 32'd0);

      // A digit offered during DRAIN is dropped and flagged.
      ra = {17'h00444, 17'h00333, 17'h00222, 17'h00111};
      push_model(ra, z, z);
      send(ra, z, z, S-1);
      digit_valid_i = 1'b1;
      RES_i = 17'h1DEAD;
      @(posedge clock_i); #1;
      digit_valid_i = 1'b0;
      wait_idle();
      chk("err_valid_in_drain", 32'(err_o), 32'd1);

      // Asynchronous reset in the middle of a drain.
      rdy_tog = 1'b1;
      push_model(ra, z, z);
      send(ra, z, z, S-1);
      @(posedge clock_i); #3;
      reset_i = 1'b1;
      #1;
      chk("arst_valid", 32'(res_valid_o), 32'd0);
      chk("arst_last",  32'(res_last_o),  32'd0);
      chk("arst_top",   32'(top_o),       32'd0);
      chk("arst_busy",  32'(busy_o),      32'd0);
      chk("arst_err",   32'(err_o),       32'd0);
      exp_q.delete();
      rdy_tog = 1'b0;
      repeat (2) @(posedge clock_i);
      #1;
      reset_i = 1'b0;
      @(posedge clock_i); #1;
      ra = {17'h0F00F, 17'h1F0F0, 17'h00FFF, 17'h12121};
      ca = {17'h00000, 17'h00007, 17'h00100, 17'h1FFFF};
      push_model(ra, ca, z);
      send(ra, ca, z, S-1);
      wait_idle();
      chk("err_after_reset", 32'(err_o), 32'd0);

      // Final carry of 2 breaks the width rule.
      ca = {17'h00002, 17'h0, 17'h0, 17'h0};
      push_model(z, ca, z);
      send(z, ca, z, S-1);
      wait_idle();
      chk("err_overflow", 32'(err_o), 32'd1);

      // Early last_i at index 2: still drains S digits, and err stays set afterwards.
      reset_i = 1'b1;
      @(posedge clock_i); #1;
      reset_i = 1'b0;
      @(posedge clock_i); #1;
      push_dc();
      send({17'd0, 17'd3, 17'd2, 17'd1}, z, z, 2);
      wait_idle();
      chk("err_early_last", 32'(err_o), 32'd1);
      push_model({17'd8, 17'd7, 17'd6, 17'd5}, z, z);
      send({17'd8, 17'd7, 17'd6, 17'd5}, z, z, S-1);
      wait_idle();
      chk("err_sticky", 32'(err_o), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
